// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame with device ack.
// Optional retry on ack error or timeout is enabled by defining PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 600,
  parameter int unsigned RTS_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 75000,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       iBusClk,
  input  logic       iRstN,
  input  logic       iSend,
  input  logic [7:0] iData,
  input  logic       iPs2Clk,
  input  logic       iPs2Data,
  output logic       oPs2ClkOe,
  output logic       oPs2DataOe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oAckErr,
  output logic       oTimeout
);

  localparam int unsigned TMAX0 = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > RTS_CYCLES) ? TMAX0 : RTS_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] INH_LD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] RTS_LD = TW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] WD_LD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_TC = FW'(FILTER_LEN - 1);
  localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRY);
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_BITS, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            clk_m_q, clk_m_d, clk_s_q, clk_s_d;
  logic            dat_m_q, dat_m_d, dat_s_q, dat_s_d;
  logic            flt_q, flt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [9:0]      sh_q, sh_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      retry_q, retry_d;
  logic            nack_q, nack_d;
  logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            ack_err_q, ack_err_d, tmo_q, tmo_d;
  logic            fall, start, retry_ok;

  always_comb begin
    state_d   = state_q;
    clk_m_d   = iPs2Clk;
    clk_s_d   = clk_m_q;
    dat_m_d   = iPs2Data;
    dat_s_d   = dat_m_q;
    flt_d     = flt_q;
    fcnt_d    = '0;
    tmr_d     = tmr_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    retry_d   = retry_q;
    nack_d    = nack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    tmo_d     = tmo_q;
    fall      = 1'b0;
    start     = 1'b0;
    retry_ok  = RETRY_EN && (retry_q < RETRY_MAX);

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    if (clk_s_q != flt_q) begin
      if (fcnt_q == FLT_TC) begin
        flt_d = clk_s_q;
        fall  = flt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (iSend) begin
          cmd_d     = iData;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          tmo_d     = 1'b0;
          retry_d   = '0;
          start     = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (tmr_q == '0) begin
          state_d   = S_RTS;
          tmr_d     = RTS_LD;
          data_oe_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_RTS: begin
        if (tmr_q == '0) begin
          state_d   = S_BITS;
          tmr_d     = WD_LD;
          clk_oe_d  = 1'b0;
          bit_cnt_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_BITS, S_ACK, S_WAIT_IDLE: begin
        if (tmr_q == '0) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          if (retry_ok) begin
            retry_d = retry_q + 1'b1;
            start   = 1'b1;
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            tmo_d     = 1'b1;
            ack_err_d = 1'b0;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (state_q == S_BITS) begin
            if (fall) begin
              data_oe_d = ~sh_q[0];
              sh_d      = {1'b1, sh_q[9:1]};
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) state_d = S_ACK;
            end
          end else if (state_q == S_ACK) begin
            if (fall) begin
              nack_d  = dat_s_q;
              state_d = S_WAIT_IDLE;
            end
          end else if (clk_s_q && dat_s_q) begin
            if (nack_q && retry_ok) begin
              retry_d = retry_q + 1'b1;
              start   = 1'b1;
            end else begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              ack_err_d = nack_q;
            end
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared entry into a fresh attempt, used for the first send and for retries.
    if (start) begin
      state_d   = S_INHIBIT;
      tmr_d     = INH_LD;
      clk_oe_d  = 1'b1;
      data_oe_d = 1'b0;
      nack_d    = 1'b0;
      sh_d      = {1'b1, ~^cmd_d, cmd_d};
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge iBusClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= S_IDLE;
      clk_m_q   <= 1'b1;
      clk_s_q   <= 1'b1;
      dat_m_q   <= 1'b1;
      dat_s_q   <= 1'b1;
      flt_q     <= 1'b1;
      fcnt_q    <= '0;
      tmr_q     <= '0;
      sh_q      <= '1;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      retry_q   <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_m_q   <= clk_m_d;
      clk_s_q   <= clk_s_d;
      dat_m_q   <= dat_m_d;
      dat_s_q   <= dat_s_d;
      flt_q     <= flt_d;
      fcnt_q    <= fcnt_d;
      tmr_q     <= tmr_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      retry_q   <= retry_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign oPs2ClkOe  = clk_oe_q;
  assign oPs2DataOe = data_oe_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oAckErr    = ack_err_q;
  assign oTimeout   = tmo_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Retry scenario is compiled in when PS2_TX_RETRY_EN is defined.
module tb_ps2_host_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_oe, data_oe, busy, done, ack_err, tmo;
  logic       ps2_clk, ps2_data;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  assign ps2_clk  = ~(clk_oe | dev_clk_low);
  assign ps2_data = ~(data_oe | dev_data_low);

  ps2_host_tx dut (
    .iBusClk(clk), .iRstN(rst_n), .iSend(send), .iData(data),
    .iPs2Clk(ps2_clk), .iPs2Data(ps2_data),
    .oPs2ClkOe(clk_oe), .oPs2DataOe(data_oe), .oBusy(busy), .oDone(done),
    .oAckErr(ack_err), .oTimeout(tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    send = 1'b1;
    tick();
    send = 1'b0;
    data = ~b;
  endtask

  // Device side: follows inhibit/RTS, then clocks n_edges falling edges with the given
  // half period, sampling host data at the end of each low phase (bits 1..10).
  task automatic dev_frame(input int half, input bit nack, input int n_edges, input int glen,
                           output logic [9:0] bits, output int inh, output bit start_ok,
                           output bit ok);
    int w;
    bits = '0; inh = 0; start_ok = 1'b0; ok = 1'b1;
    w = 0;
    while (clk_oe !== 1'b1 && w < 1000) begin tick(); w++; end
    if (w >= 1000) ok = 1'b0;
    while (clk_oe === 1'b1 && data_oe !== 1'b1 && inh < 2000) begin inh++; tick(); end
    w = 0;
    while (clk_oe === 1'b1 && w < 100) begin tick(); w++; end
    if (w >= 100) ok = 1'b0;
    start_ok = data_oe;
    for (int k = 1; k <= n_edges; k++) begin
      if (glen > 0) begin
        repeat (half / 2) tick();
        dev_clk_low = 1'b1;
        repeat (glen) tick();
        dev_clk_low = 1'b0;
        repeat (half - half / 2 - glen) tick();
      end else begin
        repeat (half) tick();
      end
      dev_clk_low = 1'b1;
      if (k == 11) dev_data_low = ~nack;
      repeat (half) tick();
      if (k <= 10) bits[k-1] = ps2_data;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 80000) begin tick(); cyc++; end
  endtask

  initial begin
    logic [9:0] bits;
    int inh, cyc, d0;
    bit st, ok;

    repeat (3) tick();
    check("reset_outputs", {clk_oe, data_oe, busy, done, ack_err, tmo}, 6'b0);
    rst_n = 1'b1;
    tick();

    // 0xF4 at 12.5 kHz with ack
    send_byte(8'hF4);
    check("t1_busy_after_send", {busy, clk_oe}, 2'b11);
    dev_frame(200, 1'b0, 11, 0, bits, inh, st, ok);
    check("t1_inhibit_len", inh >= 600, 1);
    check("t1_start_bit", st, 1);
    check("t1_handshake", ok, 1);
    check("t1_frame_bits", bits, 10'h2F4);
    wait_done(cyc);
    check("t1_done", done, 1);
    check("t1_flags", {ack_err, tmo}, 2'b00);
    tick();
    check("t1_done_width_busy", {done, busy}, 2'b00);

    // 0xFF with ack, ignored second send, 1-cycle clock glitches
    send_byte(8'hFF);
    repeat (5) tick();
    data = 8'h00;
    send = 1'b1;
    tick();
    send = 1'b0;
    dev_frame(40, 1'b0, 11, 1, bits, inh, st, ok);
    check("t2_frame_bits", bits, 10'h3FF);
    wait_done(cyc);
    check("t2_done_busy", {done, busy}, 2'b11);
    tick();
    check("t2_busy_falls", {done, busy}, 2'b00);

`ifndef PS2_TX_RETRY_EN
    // 0xF4 with NACK, 3-cycle glitches
    send_byte(8'hF4);
    dev_frame(40, 1'b1, 11, 3, bits, inh, st, ok);
    check("t3_frame_bits", bits, 10'h2F4);
    wait_done(cyc);
    check("t3_flags", {done, ack_err, tmo}, 3'b110);
    repeat (20) tick();
    check("t3_ackerr_holds", ack_err, 1);

    // device never clocks
    send_byte(8'hF4);
    check("t4_flags_cleared", {ack_err, tmo}, 2'b00);
    dev_frame(40, 1'b0, 0, 0, bits, inh, st, ok);
    wait_done(cyc);
    check("t4_timeout_cycles", cyc, 75000);
    check("t4_flags", {done, ack_err, tmo}, 3'b101);
    check("t4_lines_released", {clk_oe, data_oe}, 2'b00);
    tick();
`endif

    // async reset mid-frame
    send_byte(8'h00);
    dev_frame(40, 1'b0, 5, 0, bits, inh, st, ok);
    repeat (10) tick();
    check("t5_pre_reset", {data_oe, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("t5_reset_now", {clk_oe, data_oe, busy, done}, 4'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'hF4);
    dev_frame(40, 1'b0, 11, 0, bits, inh, st, ok);
    check("t5_frame_bits", bits, 10'h2F4);
    wait_done(cyc);
    check("t5_flags", {done, ack_err, tmo}, 3'b100);
    tick();

`ifdef PS2_TX_RETRY_EN
    // NACK twice, then ack
    d0 = done_cnt;
    send_byte(8'hF4);
    dev_frame(40, 1'b1, 11, 1, bits, inh, st, ok);
    check("t6_frame1_bits", bits, 10'h2F4);
    dev_frame(40, 1'b1, 11, 1, bits, inh, st, ok);
    check("t6_frame2_bits", bits, 10'h2F4);
    check("t6_no_early_done", done_cnt - d0, 0);
    dev_frame(40, 1'b0, 11, 1, bits, inh, st, ok);
    check("t6_frame3_bits", bits, 10'h2F4);
    check("t6_handshake", ok, 1);
    wait_done(cyc);
    check("t6_flags", {done, ack_err, tmo}, 3'b100);
    tick();
    check("t6_single_done", done_cnt - d0, 1);
`else
    d0 = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
